// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone B4 classic arbiter.
// M0 is the instruction-fetch (I-cache refill) master and M1 is the
// data-memory master. Each master keeps the shared bus for its whole cyc
// tenure. Responses go back to the owner only. A watchdog aborts any
// transfer that the slave leaves unanswered for TIMEOUT_CYCLES cycles.
// Optional feature macro: WB_ARB_RR_EN. When it is defined, a tie is
// settled by round-robin. When it is undefined, M1 wins every tie.
module wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // master 0: instruction fetch
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    // master 1: data memory
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    // shared slave bus
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    // status
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    // The counter width is at least 1 bit, so that TIMEOUT_CYCLES = 0
    // (watchdog disabled) still gives a legal declaration.
    localparam int            CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam bit            WD_EN = (TIMEOUT_CYCLES != 0);

    // The state encoding is the one-hot grant vector. This lets grant_o
    // come straight from the state register.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_OWN_M0 = 2'b01,
        S_OWN_M1 = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          own_cyc, own_stb, own_we;
    logic [31:0]   own_adr, own_dat;
    logic [3:0]    own_sel;
    logic          slv_resp;
    logic          abort;
    logic          tie_m1;

`ifdef WB_ARB_RR_EN
    logic last_m1_q, last_m1_d;

    // Tie-break register: it records which master got the most recent grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_m1_q <= 1'b0;
        end else begin
            last_m1_q <= last_m1_d;
        end
    end

    // Record the winner on every new grant. The register holds otherwise.
    always_comb begin
        last_m1_d = last_m1_q;
        if (state_d != state_q && state_d != S_IDLE) begin
            last_m1_d = (state_d == S_OWN_M1);
        end
    end

    assign tie_m1 = ~last_m1_q;
`else
    assign tie_m1 = 1'b1;
`endif

    // Ownership state and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Select the owner's request signals. The result is all zero in IDLE.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        case (state_q)
            S_OWN_M0: begin
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
                own_we  = m0_we_i;
                own_adr = m0_adr_i;
                own_dat = m0_dat_i;
                own_sel = m0_sel_i;
            end
            S_OWN_M1: begin
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
                own_we  = m1_we_i;
                own_adr = m1_adr_i;
                own_dat = m1_dat_i;
                own_sel = m1_sel_i;
            end
            default: ;
        endcase
    end

    assign slv_resp = s_ack_i | s_err_i | s_rty_i;

    // The watchdog fires at the limit unless the slave answers in that
    // same cycle. A real response always wins over the abort.
    assign abort = WD_EN && (state_q != S_IDLE) && (cnt_q == LIMIT) && !slv_resp;

    // Next owner. Arbitration happens only when the bus is idle or when the
    // owner has ended its cyc tenure.
    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE || !own_cyc) begin
            if (m0_cyc_i && m1_cyc_i) begin
                state_d = tie_m1 ? S_OWN_M1 : S_OWN_M0;
            end else if (m0_cyc_i) begin
                state_d = S_OWN_M0;
            end else if (m1_cyc_i) begin
                state_d = S_OWN_M1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // Stall counter. It counts cycles in which the owner strobes and gets
    // no answer. It restarts on a response, on an abort, or on a new tenure.
    always_comb begin
        cnt_d = cnt_q;
        if (!WD_EN || state_q == S_IDLE || state_d != state_q || slv_resp || abort) begin
            cnt_d = '0;
        end else if (own_stb) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Bus-side mux and response routing. An abort masks cyc and stb for one cycle.
    always_comb begin
        s_adr_o   = own_adr;
        s_dat_o   = own_dat;
        s_sel_o   = own_sel;
        s_we_o    = own_we;
        s_cyc_o   = own_cyc & ~abort;
        s_stb_o   = own_stb & ~abort;

        m0_dat_o  = s_dat_i;
        m1_dat_o  = s_dat_i;

        m0_ack_o  = (state_q == S_OWN_M0) & s_ack_i;
        m0_err_o  = (state_q == S_OWN_M0) & (s_err_i | abort);
        m0_rty_o  = (state_q == S_OWN_M0) & s_rty_i;
        m1_ack_o  = (state_q == S_OWN_M1) & s_ack_i;
        m1_err_o  = (state_q == S_OWN_M1) & (s_err_i | abort);
        m1_rty_o  = (state_q == S_OWN_M1) & s_rty_i;

        grant_o   = state_q;
        timeout_o = abort;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter. The watchdog limit is set to 4 here.
// Directed scenarios come first, then a long randomized run that is
// compared against a transaction-level reference model.
module tb_wb_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_rty_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All DUT outputs packed into one vector for whole-interface comparisons.
    logic [143:0] act;
    assign act = {grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
                  m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o,
                  timeout_o, m0_dat_o, m1_dat_o};

    // Reference model state.
    // owner: 0 = nobody, 1 = M0, 2 = M1.
    // last:  the master granted most recently.
    // stall: unanswered strobe cycles in the current tenure.
    int mdl_owner, mdl_last, mdl_stall;

    function automatic bit mdl_abort();
        return (TO > 0) && (mdl_owner != 0) && (mdl_stall == TO) && !(s_ack_i || s_err_i || s_rty_i);
    endfunction

    function automatic logic [143:0] mdl_expect();
        logic        c, s, w, ab;
        logic [31:0] a, d;
        logic [3:0]  sl;
        logic [1:0]  g;
        logic        o0, o1;
        o0 = (mdl_owner == 1);
        o1 = (mdl_owner == 2);
        g  = {o1, o0};
        c = 0; s = 0; w = 0; a = 0; d = 0; sl = 0;
        if (o0) begin c = m0_cyc_i; s = m0_stb_i; w = m0_we_i; a = m0_adr_i; d = m0_dat_i; sl = m0_sel_i; end
        if (o1) begin c = m1_cyc_i; s = m1_stb_i; w = m1_we_i; a = m1_adr_i; d = m1_dat_i; sl = m1_sel_i; end
        ab = mdl_abort();
        return {g, c & ~ab, s & ~ab, w, a, sl, d,
                o0 & s_ack_i, o0 & (s_err_i | ab), o0 & s_rty_i,
                o1 & s_ack_i, o1 & (s_err_i | ab), o1 & s_rty_i,
                ab, s_dat_i, s_dat_i};
    endfunction

    // The model advances one bus cycle per rising edge.
    always @(posedge clk or negedge rst_n) begin : model
        int  nxt;
        bit  ab, resp, ocyc, ostb;
        if (!rst_n) begin
            mdl_owner <= 0;
            mdl_last  <= 1;
            mdl_stall <= 0;
        end else begin
            ab   = mdl_abort();
            resp = s_ack_i || s_err_i || s_rty_i;
            ocyc = (mdl_owner == 1) ? m0_cyc_i : (mdl_owner == 2) ? m1_cyc_i : 1'b0;
            ostb = (mdl_owner == 1) ? m0_stb_i : (mdl_owner == 2) ? m1_stb_i : 1'b0;
            nxt  = mdl_owner;
            if (mdl_owner == 0 || !ocyc) begin
                if (m0_cyc_i && m1_cyc_i) begin
`ifdef WB_ARB_RR_EN
                    nxt = (mdl_last == 2) ? 1 : 2;
`else
                    nxt = 2;
`endif
                end else if (m0_cyc_i) nxt = 1;
                else if (m1_cyc_i) nxt = 2;
                else nxt = 0;
            end
            if (nxt != 0 && nxt != mdl_owner) mdl_last <= nxt;
            if (nxt == 0 || nxt != mdl_owner || resp || ab) mdl_stall <= 0;
            else if (ostb) mdl_stall <= mdl_stall + 1;
            mdl_owner <= nxt;
        end
    end

    task automatic idle_inputs();
        m0_adr_i = 0; m0_dat_i = 0; m0_sel_i = 0; m0_we_i = 0; m0_stb_i = 0; m0_cyc_i = 0;
        m1_adr_i = 0; m1_dat_i = 0; m1_sel_i = 0; m1_we_i = 0; m1_stb_i = 0; m1_cyc_i = 0;
        s_dat_i = 0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (act !== 144'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h want=0", act);
        end
        n_cmp++;
        if (grant_o !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_grant got=%b want=00", grant_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_m0();
        @(posedge clk); #1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h8000_0000; m0_sel_i = 4'hF; m0_we_i = 0;
        @(negedge clk);
        n_cmp++;
        if ({grant_o, s_cyc_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL m0_pre_grant got=%b want=000", {grant_o, s_cyc_o});
        end
        @(posedge clk); #1;
        s_ack_i = 1; s_dat_i = 32'h0000_0013;
        @(negedge clk);
        n_cmp++;
        if ({grant_o, s_stb_o, s_adr_o} !== {2'b01, 1'b1, 32'h8000_0000}) begin
            n_bad++;
            $display("FAIL m0_grant got=%b/%b/%h want=01/1/80000000", grant_o, s_stb_o, s_adr_o);
        end
        n_cmp++;
        if ({m0_ack_o, m0_dat_o, m1_ack_o} !== {1'b1, 32'h0000_0013, 1'b0}) begin
            n_bad++;
            $display("FAIL m0_ack got=%b/%h/%b want=1/00000013/0", m0_ack_o, m0_dat_o, m1_ack_o);
        end
        @(posedge clk); #1;
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({grant_o, s_cyc_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL m0_release got=%b want=000", {grant_o, s_cyc_o});
        end
    endtask

    task automatic test_tie_handoff();
        @(posedge clk); #1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0100;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h1000_0004; m1_we_i = 1; m1_dat_i = 32'hCAFE_0001;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({grant_o, s_adr_o, s_we_o, s_dat_o} !== {2'b10, 32'h1000_0004, 1'b1, 32'hCAFE_0001}) begin
            n_bad++;
            $display("FAIL tie_grant got=%b/%h want=10/10000004", grant_o, s_adr_o);
        end
        @(posedge clk); #1;
        s_ack_i = 1;
        @(negedge clk);
        n_cmp++;
        if ({m1_ack_o, m0_ack_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL tie_ack_route got=%b want=10", {m1_ack_o, m0_ack_o});
        end
        @(posedge clk); #1;
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({grant_o, s_adr_o, s_stb_o} !== {2'b01, 32'h0000_0100, 1'b1}) begin
            n_bad++;
            $display("FAIL handoff got=%b/%h/%b want=01/00000100/1", grant_o, s_adr_o, s_stb_o);
        end
        @(posedge clk); #1;
        m0_cyc_i = 0; m0_stb_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        for (int r = 0; r < 4; r++) begin
`ifdef WB_ARB_RR_EN
            want = (r % 2 == 0) ? 2'b10 : 2'b01;
`else
            want = 2'b10;
`endif
            @(posedge clk); #1;
            m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if (grant_o !== want) begin
                n_bad++;
                $display("FAIL tie_round%0d got=%b want=%b", r, grant_o, want);
            end
            @(posedge clk); #1;
            m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_watchdog();
        @(posedge clk); #1;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h2000_0000; m1_dat_i = 32'h1234_5678;
        @(posedge clk); #1;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({s_stb_o, m1_err_o, timeout_o} !== 3'b100) begin
                n_bad++;
                $display("FAIL wd_stall%0d got=%b want=100", k, {s_stb_o, m1_err_o, timeout_o});
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++;
        if ({grant_o, s_cyc_o, s_stb_o, m1_err_o, m0_err_o, timeout_o} !== 7'b10_00101) begin
            n_bad++;
            $display("FAIL wd_abort got=%b want=1000101",
                     {grant_o, s_cyc_o, s_stb_o, m1_err_o, m0_err_o, timeout_o});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({grant_o, s_stb_o, m1_err_o, timeout_o} !== 5'b10_100) begin
            n_bad++;
            $display("FAIL wd_after got=%b want=10100", {grant_o, s_stb_o, m1_err_o, timeout_o});
        end
        @(posedge clk); #1;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_ack_at_limit();
        @(posedge clk); #1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0040;
        @(posedge clk); #1;
        for (int k = 0; k < TO; k++) begin
            @(posedge clk); #1;
        end
        s_ack_i = 1; s_dat_i = 32'hA5A5_0000;
        @(negedge clk);
        n_cmp++;
        if ({m0_ack_o, m0_err_o, timeout_o, s_stb_o} !== 4'b1001) begin
            n_bad++;
            $display("FAIL ack_at_limit got=%b want=1001", {m0_ack_o, m0_err_o, timeout_o, s_stb_o});
        end
        @(posedge clk); #1;
        s_ack_i = 0;
        @(negedge clk);
        n_cmp++;
        if ({m0_err_o, timeout_o, s_stb_o} !== 3'b001) begin
            n_bad++;
            $display("FAIL ack_limit_after got=%b want=001", {m0_err_o, timeout_o, s_stb_o});
        end
        @(posedge clk); #1;
        m0_cyc_i = 0; m0_stb_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0800;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (grant_o !== 2'b01) begin
            n_bad++;
            $display("FAIL rst_mid_pre got=%b want=01", grant_o);
        end
        #2;
        rst_n = 0; s_ack_i = 1;
        #1;
        n_cmp++;
        if ({grant_o, s_cyc_o, s_stb_o, m0_ack_o} !== 5'b00000) begin
            n_bad++;
            $display("FAIL rst_mid_drop got=%b want=00000", {grant_o, s_cyc_o, s_stb_o, m0_ack_o});
        end
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h3000_0000;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({grant_o, s_stb_o} !== 3'b101) begin
            n_bad++;
            $display("FAIL rst_mid_regrant got=%b want=101", {grant_o, s_stb_o});
        end
        @(posedge clk); #1;
        m1_cyc_i = 0; m1_stb_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [143:0] want;
        int r;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!m0_cyc_i) m0_cyc_i = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 7) == 0) m0_cyc_i = 0;
            if (!m1_cyc_i) m1_cyc_i = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 7) == 0) m1_cyc_i = 0;
            m0_stb_i = m0_cyc_i & ($urandom_range(0, 3) != 0);
            m1_stb_i = m1_cyc_i & ($urandom_range(0, 3) != 0);
            m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
            m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
            s_dat_i = $urandom;
            r = $urandom_range(0, 9);
            s_ack_i = (r == 0);
            s_err_i = (r == 1);
            s_rty_i = (r == 2);
            @(negedge clk);
            want = mdl_expect();
            n_cmp++;
            if (act !== want) begin
                n_bad++;
                $display("FAIL random_cycle%0d got=%h want=%h", i, act, want);
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_m0();
        test_tie_handoff();
        test_round_robin();
        test_watchdog();
        test_ack_at_limit();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
